// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and encodings for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// rtl/hazard_controller_forward_unit.sv - E-stage operand forwarding selects, M result preferred over W
module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs1E,
  input  logic [REG_W-1:0] rs2E,
  input  logic [REG_W-1:0] rdM,
  input  logic [REG_W-1:0] rdW,
  input  logic             regwriteM,
  input  logic             regwriteW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE
);

  // x0 is hardwired zero, so a write to it must never be forwarded
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
    if (regwriteM && (rdM != '0) && (rdM == rs))
      return FWD_M;
    else if (regwriteW && (rdW != '0) && (rdW == rs))
      return FWD_W;
    else
      return FWD_RF;
  endfunction

  always_comb begin
    forwardAE = fwd_sel(rs1E);
    forwardBE = fwd_sel(rs2E);
  end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush/forward control with memory-miss hold FSM and perf counters
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1D,
  input  logic [REG_W-1:0] rs2D,
  input  logic [REG_W-1:0] rs1E,
  input  logic [REG_W-1:0] rs2E,
  input  logic [REG_W-1:0] rdE,
  input  logic [REG_W-1:0] rdM,
  input  logic [REG_W-1:0] rdW,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic [1:0]       resultsrcE,
  input  logic             pcsrcE,
  input  logic             cache_missM,
  input  logic             mem_readyM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             mem_errorM,
  output logic [CNT_W-1:0] cnt_lwstall,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_memwait
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic              timeout_hit;
  logic              lwstall, memhold, flush_win, lw_win;

  forward_unit #(.REG_W(REG_W)) u_forward (
    .rs1E      (rs1E),
    .rs2E      (rs2E),
    .rdM       (rdM),
    .rdW       (rdW),
    .regwriteM (regwriteM),
    .regwriteW (regwriteW),
    .forwardAE (forwardAE),
    .forwardBE (forwardBE)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      wait_cnt   <= '0;
      mem_errorM <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (timeout_hit)
        mem_errorM <= 1'b1;
    end
  end

  // Timeout fires on the edge where the wait counter would reach TIMEOUT-1
  always_comb begin
    state_next  = state;
    wait_next   = wait_cnt;
    timeout_hit = 1'b0;
    case (state)
      RUN: begin
        if (cache_missM) begin
          state_next = MEM_WAIT;
          wait_next  = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_readyM) begin
          state_next = RUN;
        end else begin
          wait_next = wait_cnt + 1'b1;
          if (wait_next == WAIT_W'(TIMEOUT - 1)) begin
            timeout_hit = 1'b1;
            state_next  = RUN;
          end
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    lwstall   = (resultsrcE == RESULTSRC_LOAD) && (rdE != '0) &&
                ((rdE == rs1D) || (rdE == rs2D));
    memhold   = ((state == RUN) && cache_missM) ||
                ((state == MEM_WAIT) && !mem_readyM);
    flush_win = !memhold && pcsrcE;
    lw_win    = !memhold && !pcsrcE && lwstall;

    stallF = memhold || lw_win;
    stallD = memhold || lw_win;
    stallE = memhold;
    stallM = memhold;
    flushW = memhold;
    flushD = flush_win;
    flushE = flush_win || lw_win;
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lwstall <= '0;
      cnt_flush   <= '0;
      cnt_memwait <= '0;
    end else begin
      if (lw_win)    cnt_lwstall <= sat_inc(cnt_lwstall);
      if (flush_win) cnt_flush   <= sat_inc(cnt_flush);
      if (memhold)   cnt_memwait <= sat_inc(cnt_memwait);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       regwriteM, regwriteW, pcsrcE, cache_missM, mem_readyM;
  logic [1:0] resultsrcE;

  logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_errorM;
  logic [1:0]  forwardAE, forwardBE;
  logic [15:0] cnt_lwstall, cnt_flush, cnt_memwait;

  logic        s_stallF, s_stallD, s_stallE, s_stallM, s_flushD, s_flushE, s_flushW, s_mem_errorM;
  logic [1:0]  s_forwardAE, s_forwardBE;
  logic [1:0]  s_cnt_lwstall, s_cnt_flush, s_cnt_memwait;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .resultsrcE(resultsrcE), .pcsrcE(pcsrcE), .cache_missM(cache_missM),
    .mem_readyM(mem_readyM), .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .stallM(stallM), .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .mem_errorM(mem_errorM),
    .cnt_lwstall(cnt_lwstall), .cnt_flush(cnt_flush), .cnt_memwait(cnt_memwait)
  );

  // Narrow-counter copy for observing saturation in a few cycles
  hazard_controller #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .resultsrcE(resultsrcE), .pcsrcE(pcsrcE), .cache_missM(cache_missM),
    .mem_readyM(mem_readyM), .stallF(s_stallF), .stallD(s_stallD), .stallE(s_stallE),
    .stallM(s_stallM), .flushD(s_flushD), .flushE(s_flushE), .flushW(s_flushW),
    .forwardAE(s_forwardAE), .forwardBE(s_forwardBE), .mem_errorM(s_mem_errorM),
    .cnt_lwstall(s_cnt_lwstall), .cnt_flush(s_cnt_flush), .cnt_memwait(s_cnt_memwait)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
    regwriteM = 1'b0; regwriteW = 1'b0; resultsrcE = 2'b00;
    pcsrcE = 1'b0; cache_missM = 1'b0; mem_readyM = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_stallF", stallF, 0);
    chk("reset_flushW", flushW, 0);
    chk("reset_flushD", flushD, 0);
    chk("reset_fwdA", forwardAE, 0);
    chk("reset_err", mem_errorM, 0);
    chk("reset_cnt_mem", cnt_memwait, 0);

    rs1E = 5; rdM = 5; regwriteM = 1'b1; rdW = 5; regwriteW = 1'b1;
    #1 chk("fwdA_M_priority", forwardAE, 2'b10);
    rdM = 0;
    #1 chk("fwdA_W_rdM0", forwardAE, 2'b01);
    rs2E = 5;
    #1 chk("fwdB_W", forwardBE, 2'b01);
    regwriteW = 1'b0;
    #1 chk("fwdA_none", forwardAE, 2'b00);
    rs1E = 0; rs2E = 0; rdW = 0; regwriteM = 1'b0;

    tick();
    resultsrcE = 2'b01; rdE = 7; rs2D = 7;
    #1;
    chk("lw_stallF", stallF, 1);
    chk("lw_stallD", stallD, 1);
    chk("lw_flushE", flushE, 1);
    chk("lw_stallE", stallE, 0);
    tick();
    chk("lw_cnt", cnt_lwstall, 1);
    rdE = 0;
    #1;
    chk("lw_rd0_stallF", stallF, 0);
    chk("lw_rd0_flushE", flushE, 0);
    tick();
    chk("lw_rd0_cnt", cnt_lwstall, 1);

    rdE = 7; pcsrcE = 1'b1;
    #1;
    chk("br_flushD", flushD, 1);
    chk("br_flushE", flushE, 1);
    chk("br_stallF", stallF, 0);
    tick();
    chk("br_cnt_flush", cnt_flush, 1);
    chk("br_cnt_lw", cnt_lwstall, 1);
    rdE = 0; rs2D = 0; resultsrcE = 2'b00;

    cache_missM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("miss_stallF", stallF, 1);
      chk("miss_stallM", stallM, 1);
      chk("miss_flushW", flushW, 1);
      chk("miss_flushD", flushD, 0);
      tick();
      cache_missM = 1'b0;
    end
    mem_readyM = 1'b1;
    #1;
    chk("rel_stallF", stallF, 0);
    chk("rel_stallE", stallE, 0);
    chk("rel_flushW", flushW, 0);
    chk("rel_flushD", flushD, 1);
    chk("rel_cnt_mem", cnt_memwait, 4);
    tick();
    chk("rel_cnt_flush", cnt_flush, 2);
    mem_readyM = 1'b0; pcsrcE = 1'b0;
    #1 chk("run_ready_ignored", stallF, 0);

    cache_missM = 1'b1;
    tick();
    cache_missM = 1'b0;
    for (int i = 0; i < 63; i++) begin
      #1;
      chk("to_err_low", mem_errorM, 0);
      chk("to_stallF", stallF, 1);
      tick();
    end
    chk("to_err_set", mem_errorM, 1);
    chk("to_released", stallF, 0);
    chk("to_cnt_mem", cnt_memwait, 4 + 64);
    tick(); tick(); tick();
    chk("to_err_sticky", mem_errorM, 1);
    chk("to_still_run", stallF, 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_err_clr", mem_errorM, 0);
    cache_missM = 1'b1; pcsrcE = 1'b1;
    tick();
    cache_missM = 1'b0;
    tick();
    tick();
    #1 chk("mw3_stallF", stallF, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_stallF", stallF, 0);
    chk("rst_mid_flushW", flushW, 0);
    chk("rst_mid_run", flushD, 1);
    chk("rst_mid_cnt_mem", cnt_memwait, 0);
    chk("rst_mid_cnt_flush", cnt_flush, 0);
    chk("rst_mid_cnt_lw", cnt_lwstall, 0);

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_flush", s_cnt_flush, (i >= 2) ? 3 : i + 1);
      chk("wide_flush", cnt_flush, i + 1);
    end
    pcsrcE = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Sequences the 5-stage pipeline (F/D/E/M/W) around the decode stage: stall, flush and forwarding-select generation.
- Holds the pipeline through multi-cycle data-memory misses with a small FSM and a timeout.
- Keeps saturating performance counters for the load-use stall, flush and memory-wait cycles it causes.
- Sits beside the datapath. It drives the enables and clears of the F/D, D/E, E/M and M/W pipeline registers and the E-stage operand muxes.

Parameters:
- REG_W, 5, register-index width.
- CNT_W, 16, performance-counter width.
- TIMEOUT, 64, maximum MEM_WAIT cycles before a memory error is flagged.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- rs1D  in  REG_W  source 1 of the instruction in D
- rs2D  in  REG_W  source 2 of the instruction in D
- rs1E  in  REG_W  source 1 of the instruction in E
- rs2E  in  REG_W  source 2 of the instruction in E
- rdE  in  REG_W  destination register in E
- rdM  in  REG_W  destination register in M
- rdW  in  REG_W  destination register in W
- regwriteM  in  1  M-stage instruction writes the register file
- regwriteW  in  1  W-stage instruction writes the register file
- resultsrcE  in  2  E-stage result source; 2'b01 means load
- pcsrcE  in  1  branch or jump taken, resolved in E
- cache_missM  in  1  M-stage access missed
- mem_readyM  in  1  miss data valid this cycle
- stallF, stallD, stallE, stallM  out  1 each  hold the corresponding pipeline register
- flushD, flushE, flushW  out  1 each  clear the corresponding pipeline register (insert a bubble)
- forwardAE, forwardBE  out  2 each  operand select: 00 = register file, 01 = W result, 10 = M ALU result
- mem_errorM  out  1  sticky; set on timeout
- cnt_lwstall, cnt_flush, cnt_memwait  out  CNT_W each  performance counters

Behaviour:
- Reset (synchronous, rst high at a clk edge): state = RUN; mem_errorM = 0; all counters = 0; wait counter = 0. All outputs depend only on state and inputs, so after reset with idle inputs every stall and flush = 0 and every forward select = 00.
- Forwarding (combinational; applies in every state):
  - forwardAE = 10 if regwriteM and rdM != 0 and rdM == rs1E.
  - Otherwise forwardAE = 01 if regwriteW and rdW != 0 and rdW == rs1E.
  - Otherwise forwardAE = 00. M has priority over W.
  - forwardBE is identical, using rs2E.
- lwstall = (resultsrcE == 01) and rdE != 0 and (rdE == rs1D or rdE == rs2D).
- Define memhold = (state == RUN and cache_missM) or (state == MEM_WAIT and not mem_readyM).
- Priority: memhold > pcsrcE > lwstall.
  - If memhold: stallF = stallD = stallE = stallM = 1; flushW = 1; flushD = flushE = 0. pcsrcE and lwstall are ignored; they are re-evaluated when the hold releases.
  - Else if pcsrcE: flushD = flushE = 1; no stalls.
  - Else if lwstall: stallF = stallD = 1; flushE = 1.
  - Else: all stall and flush outputs = 0.
- FSM:
  - RUN --cache_missM--> MEM_WAIT, wait counter cleared to 0.
  - MEM_WAIT --mem_readyM--> RUN. The stall releases in the same cycle mem_readyM is high, so the miss costs exactly the number of cycles spent in RUN-miss plus MEM_WAIT-not-ready.
  - MEM_WAIT, not ready: wait counter += 1. When the counter reaches TIMEOUT-1 and mem_readyM is still low: set mem_errorM, return to RUN, release the stall.
  - mem_readyM is ignored in RUN. cache_missM is ignored in MEM_WAIT.
- Counters (saturating at all-ones, never wrap):
  - cnt_memwait += 1 for each memhold cycle.
  - cnt_flush += 1 for each cycle where pcsrcE wins priority.
  - cnt_lwstall += 1 for each cycle where lwstall wins priority.
- rst asserted mid-miss: the next state is RUN and all counters and mem_errorM clear, regardless of other inputs.

Decomposition:
- hazard_pkg holds:
  - the state enum {RUN, MEM_WAIT};
  - forward-select constants FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
  - the load encoding RESULTSRC_LOAD = 2'b01.
- Sub-module forward_unit (purely combinational): instantiated once and outputs both forwardAE and forwardBE.

Test Plan:
- rs1E = 5, rdM = 5, regwriteM = 1, rdW = 5, regwriteW = 1 -> forwardAE = 10. Same with rdM = 0 -> forwardAE = 01.
- resultsrcE = 01, rdE = 7, rs2D = 7 for one cycle -> stallF = stallD = 1, flushE = 1, cnt_lwstall = 1. Same with rdE = 0 -> no stall.
- pcsrcE = 1 and lwstall both true -> flushD = flushE = 1, stallF = 0, cnt_flush increments, cnt_lwstall unchanged.
- cache_missM = 1, then mem_readyM = 1 on the 4th MEM_WAIT cycle:
  - stalls = 1 and flushW = 1 for 4 cycles, 0 on the ready cycle;
  - cnt_memwait = 4;
  - pcsrcE held high throughout produces flushD only on the release cycle.
- Miss with mem_readyM never asserted, TIMEOUT = 64 -> mem_errorM rises after 64 memhold cycles, the FSM returns to RUN, and mem_errorM stays set until rst.
- rst pulsed in the 3rd MEM_WAIT cycle -> the next cycle shows state RUN, stalls = 0, all counters = 0. Force cnt_flush to all-ones -> a further flush leaves it at all-ones.
